// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: funct3 size codes, result-select encodings
// and the data-memory bus FSM state type.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RESULT_MEM = 2'b01;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RVALID
   } dmem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane handling for the MEM stage: store byte enables and lane replication,
// misalignment detection, and load byte/half extraction with extension.
module lsu_align
   import riscv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [2:0]            i_f3,
   input  logic                  i_load,
   input  logic [1:0]            i_offset,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [DATA_WIDTH-1:0] i_rdata,
   output logic [3:0]            o_store_be,
   output logic [DATA_WIDTH-1:0] o_store_wdata,
   output logic                  o_misaligned,
   output logic [DATA_WIDTH-1:0] o_load_data
);

   logic        is_byte;
   logic        is_half;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // The unsigned codes only mean byte/half for loads; a store with them is a word.
   always_comb begin
      is_byte = (i_f3 == F3_B) || (i_load && (i_f3 == F3_BU));
      is_half = (i_f3 == F3_H) || (i_load && (i_f3 == F3_HU));
      if (is_half) begin
         o_misaligned = i_offset[0];
      end else if (is_byte) begin
         o_misaligned = 1'b0;
      end else begin
         o_misaligned = (i_offset != 2'b00);
      end
   end

   always_comb begin
      o_store_be    = 4'b1111;
      o_store_wdata = i_wdata;
      case (i_f3)
         F3_B: begin
            o_store_be    = 4'b0001 << i_offset;
            o_store_wdata = {4{i_wdata[7:0]}};
         end
         F3_H: begin
            o_store_be    = i_offset[1] ? 4'b1100 : 4'b0011;
            o_store_wdata = {2{i_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      unique case (i_offset)
         2'd0: rd_byte = i_rdata[7:0];
         2'd1: rd_byte = i_rdata[15:8];
         2'd2: rd_byte = i_rdata[23:16];
         2'd3: rd_byte = i_rdata[31:24];
      endcase
      rd_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_f3)
         F3_B:    o_load_data = {{24{rd_byte[7]}}, rd_byte};
         F3_H:    o_load_data = {{16{rd_half[15]}}, rd_half};
         F3_BU:   o_load_data = {24'h0, rd_byte};
         F3_HU:   o_load_data = {16'h0, rd_half};
         F3_W:    o_load_data = i_rdata;
         default: o_load_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: drives the req/gnt/rvalid data-memory bus, stalls the pipeline while
// a transaction is outstanding, and owns the MEM/WB pipeline register.
module memory_stage
   import riscv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_alu_result_m,
   input  logic [DATA_WIDTH-1:0] i_write_data_m,
   input  logic                  i_regwrite_m,
   input  logic                  i_memwrite_m,
   input  logic [1:0]            i_resultsrc_m,
   input  logic [4:0]            i_rd_addr_m,
   input  logic [ADDR_WIDTH-1:0] i_pc4_m,
   input  logic [2:0]            i_f3_m,
   output logic [DATA_WIDTH-1:0] o_forward_m,
   output logic                  o_stall_m,
   output logic                  o_dmem_req,
   output logic                  o_dmem_we,
   output logic [3:0]            o_dmem_be,
   output logic [ADDR_WIDTH-1:0] o_dmem_addr,
   output logic [DATA_WIDTH-1:0] o_dmem_wdata,
   input  logic                  i_dmem_gnt,
   input  logic                  i_dmem_rvalid,
   input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
   output logic                  o_regwrite_w,
   output logic [1:0]            o_resultsrc_w,
   output logic [DATA_WIDTH-1:0] o_alu_result_w,
   output logic [DATA_WIDTH-1:0] o_read_data_w,
   output logic [4:0]            o_rd_addr_w,
   output logic [ADDR_WIDTH-1:0] o_pc4_w,
   output logic                  o_misaligned_w
);

   dmem_state_t state_q, state_d;

   logic                  load;
   logic                  store;
   logic                  access;
   logic                  misaligned;
   logic                  bad_access;
   logic                  req;
   logic                  stall;
   logic [3:0]            store_be;
   logic [DATA_WIDTH-1:0] load_data;

   assign load       = (i_resultsrc_m == RESULT_MEM);
   assign store      = i_memwrite_m;
   assign access     = load | store;
   assign bad_access = access & misaligned;

   lsu_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_lsu_align (
      .i_f3          (i_f3_m),
      .i_load        (load),
      .i_offset      (i_alu_result_m[1:0]),
      .i_wdata       (i_write_data_m),
      .i_rdata       (i_dmem_rdata),
      .o_store_be    (store_be),
      .o_store_wdata (o_dmem_wdata),
      .o_misaligned  (misaligned),
      .o_load_data   (load_data)
   );

   assign o_forward_m = i_alu_result_m;
   assign o_dmem_addr = {i_alu_result_m[ADDR_WIDTH-1:2], 2'b00};
   assign o_dmem_we   = store;
   assign o_dmem_be   = store ? store_be : 4'b1111;

   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      stall   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (access && !misaligned) begin
               req = 1'b1;
               if (!i_dmem_gnt) begin
                  stall   = 1'b1;
                  state_d = WAIT_GNT;
               end else if (!store) begin
                  stall   = 1'b1;
                  state_d = WAIT_RVALID;
               end
            end
         end
         WAIT_GNT: begin
            req   = 1'b1;
            stall = 1'b1;
            if (i_dmem_gnt) begin
               if (store) begin
                  stall   = 1'b0;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT_RVALID;
               end
            end
         end
         WAIT_RVALID: begin
            stall = 1'b1;
            if (i_dmem_rvalid) begin
               stall   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset forces the bus and pipeline quiet even though inputs may still request.
   assign o_dmem_req = req & i_rst_n;
   assign o_stall_m  = stall & i_rst_n;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_regwrite_w   <= 1'b0;
         o_resultsrc_w  <= 2'b00;
         o_alu_result_w <= '0;
         o_read_data_w  <= '0;
         o_rd_addr_w    <= 5'd0;
         o_pc4_w        <= '0;
         o_misaligned_w <= 1'b0;
      end else if (stall) begin
         o_regwrite_w   <= 1'b0;
         o_resultsrc_w  <= 2'b00;
         o_alu_result_w <= '0;
         o_read_data_w  <= '0;
         o_rd_addr_w    <= 5'd0;
         o_pc4_w        <= '0;
         o_misaligned_w <= 1'b0;
      end else begin
         o_regwrite_w   <= i_regwrite_m & ~bad_access;
         o_resultsrc_w  <= i_resultsrc_m;
         o_alu_result_w <= i_alu_result_m;
         o_read_data_w  <= (load && !misaligned) ? load_data : '0;
         o_rd_addr_w    <= i_rd_addr_m;
         o_pc4_w        <= i_pc4_m;
         o_misaligned_w <= bad_access;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed and randomized accesses checked
// against a behavioural model of the bus timeline and lane rules.
module tb_memory_stage;

   localparam int DW = 32;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] alu_result = '0;
   logic [DW-1:0] write_data = '0;
   logic          regwrite = 1'b0;
   logic          memwrite = 1'b0;
   logic [1:0]    resultsrc = 2'b00;
   logic [4:0]    rd_addr = '0;
   logic [AW-1:0] pc4 = '0;
   logic [2:0]    f3 = '0;
   logic          gnt = 1'b0;
   logic          rvalid = 1'b0;
   logic [DW-1:0] rdata = '0;

   logic [DW-1:0] forward;
   logic          stall;
   logic          req;
   logic          we;
   logic [3:0]    be;
   logic [AW-1:0] daddr;
   logic [DW-1:0] wdata;
   logic          regwrite_w;
   logic [1:0]    resultsrc_w;
   logic [DW-1:0] alu_result_w;
   logic [DW-1:0] read_data_w;
   logic [4:0]    rd_addr_w;
   logic [AW-1:0] pc4_w;
   logic          misaligned_w;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   memory_stage #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_alu_result_m (alu_result),
      .i_write_data_m (write_data),
      .i_regwrite_m   (regwrite),
      .i_memwrite_m   (memwrite),
      .i_resultsrc_m  (resultsrc),
      .i_rd_addr_m    (rd_addr),
      .i_pc4_m        (pc4),
      .i_f3_m         (f3),
      .o_forward_m    (forward),
      .o_stall_m      (stall),
      .o_dmem_req     (req),
      .o_dmem_we      (we),
      .o_dmem_be      (be),
      .o_dmem_addr    (daddr),
      .o_dmem_wdata   (wdata),
      .i_dmem_gnt     (gnt),
      .i_dmem_rvalid  (rvalid),
      .i_dmem_rdata   (rdata),
      .o_regwrite_w   (regwrite_w),
      .o_resultsrc_w  (resultsrc_w),
      .o_alu_result_w (alu_result_w),
      .o_read_data_w  (read_data_w),
      .o_rd_addr_w    (rd_addr_w),
      .o_pc4_w        (pc4_w),
      .o_misaligned_w (misaligned_w)
   );

   // ---------------- reference model ----------------
   function automatic int acc_size(input logic [2:0] code, input logic is_load);
      if (code == 3'b000 || (is_load && code == 3'b100)) return 1;
      if (code == 3'b001 || (is_load && code == 3'b101)) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] code, input logic [31:0] addr,
                                              input logic [31:0] word);
      logic [31:0]        sh;
      logic signed [7:0]  sb;
      logic signed [15:0] shw;
      sh  = word >> (8 * int'(addr[1:0]));
      sb  = sh[7:0];
      shw = sh[15:0];
      case (code)
         3'b000:  return int'(sb);
         3'b001:  return int'(shw);
         3'b100:  return sh & 32'h0000_00FF;
         3'b101:  return sh & 32'h0000_FFFF;
         default: return word;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] code, input logic [31:0] addr,
                                           input logic is_store);
      int mask;
      if (!is_store) return 4'hF;
      mask = (1 << acc_size(code, 1'b0)) - 1;
      return 4'(mask << int'(addr[1:0]));
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] code, input logic [31:0] wd);
      case (acc_size(code, 1'b0))
         1:       return {24'h0, wd[7:0]} * 32'h0101_0101;
         2:       return {16'h0, wd[15:0]} * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   // One transaction: drives it, walks the expected bus timeline cycle by cycle.
   task automatic run_access(input string name, input logic is_load, input logic is_store,
                             input logic [2:0] code, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] word, input logic rw,
                             input logic [1:0] rsrc, input logic [4:0] rd,
                             input logic [9:0] p4, input int gdel, input int rdel);
      logic        access, mis, exp_req, exp_stall, done;
      logic [31:0] exp_rd;
      logic [9:0]  exp_addr;
      access   = is_load | is_store;
      mis      = access && ((int'(addr[1:0]) % acc_size(code, is_load)) != 0);
      exp_rd   = (is_load && !mis) ? model_load(code, addr, word) : 32'h0;
      exp_addr = 10'(addr & ~32'h3);
      alu_result = addr;  write_data = wd;  regwrite = rw;  memwrite = is_store;
      resultsrc  = is_load ? 2'b01 : rsrc;  rd_addr = rd;  pc4 = p4;  f3 = code;
      rdata = word;
      done = 1'b0;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         gnt = 1'b0;  rvalid = 1'b0;
         if (!access || mis) begin
            exp_req = 1'b0;  exp_stall = 1'b0;  done = 1'b1;
         end else if (cyc <= gdel) begin
            exp_req = 1'b1;  gnt = (cyc == gdel);
            exp_stall = !(is_store && gnt);  done = is_store && gnt;
         end else begin
            exp_req = 1'b0;  rvalid = (cyc == gdel + rdel);
            exp_stall = !rvalid;  done = rvalid;
         end
         @(negedge clk);
         vectors++;
         if (req !== exp_req || stall !== exp_stall) begin
            miscompares++;
            $display("FAIL %s cyc%0d req/stall: got %b/%b expected %b/%b", name, cyc, req, stall,
                     exp_req, exp_stall);
         end
         vectors++;
         if (forward !== addr) begin
            miscompares++;
            $display("FAIL %s forward: got %h expected %h", name, forward, addr);
         end
         if (exp_req) begin
            vectors++;
            if (we !== is_store || be !== model_be(code, addr, is_store) || daddr !== exp_addr ||
                (is_store && wdata !== model_wdata(code, wd))) begin
               miscompares++;
               $display("FAIL %s cyc%0d bus: got we=%b be=%b addr=%h wdata=%h expected %b/%b/%h/%h",
                        name, cyc, we, be, daddr, wdata, is_store, model_be(code, addr, is_store),
                        exp_addr, model_wdata(code, wd));
            end
         end
         @(posedge clk);
         #1;
         gnt = 1'b0;  rvalid = 1'b0;
         vectors++;
         if (exp_stall) begin
            if (regwrite_w !== 1'b0 || misaligned_w !== 1'b0) begin
               miscompares++;
               $display("FAIL %s cyc%0d bubble: got rw_w=%b mis_w=%b expected 0/0", name, cyc,
                        regwrite_w, misaligned_w);
            end
         end else if (regwrite_w !== (rw & ~mis) || misaligned_w !== mis ||
                      read_data_w !== exp_rd || alu_result_w !== addr || rd_addr_w !== rd ||
                      pc4_w !== p4 || resultsrc_w !== resultsrc) begin
            miscompares++;
            $display("FAIL %s memwb: got rw=%b mis=%b rdata=%h alu=%h rd=%0d pc4=%h src=%b expected %b/%b/%h/%h/%0d/%h/%b",
                     name, regwrite_w, misaligned_w, read_data_w, alu_result_w, rd_addr_w, pc4_w,
                     resultsrc_w, rw & ~mis, mis, exp_rd, addr, rd, p4, resultsrc);
         end
      end
   endtask

   task automatic drive_idle();
      alu_result = '0;  write_data = '0;  regwrite = 1'b0;  memwrite = 1'b0;
      resultsrc = 2'b00;  rd_addr = '0;  pc4 = '0;  f3 = '0;  gnt = 1'b0;  rvalid = 1'b0;
   endtask

   task automatic check_quiet(input string name);
      vectors++;
      if (req !== 1'b0 || stall !== 1'b0 || regwrite_w !== 1'b0 || read_data_w !== 32'h0 ||
          alu_result_w !== 32'h0 || misaligned_w !== 1'b0 || pc4_w !== 10'h0) begin
         miscompares++;
         $display("FAIL %s: got req=%b stall=%b rw_w=%b rdata_w=%h alu_w=%h mis_w=%b pc4_w=%h expected all 0",
                  name, req, stall, regwrite_w, read_data_w, alu_result_w, misaligned_w, pc4_w);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      alu_result = 32'h8;  resultsrc = 2'b01;  f3 = 3'b010;  regwrite = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      rst_n = 1'b1;
      drive_idle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      run_access("sb_lane2", 1'b0, 1'b1, 3'b000, 32'h6, 32'h1234_56AB, 32'h0, 1'b0, 2'b00, 5'd0,
                 10'h10, 0, 0);
      run_access("lh_sext", 1'b1, 1'b0, 3'b001, 32'h2, 32'h0, 32'h8001_0000, 1'b1, 2'b00, 5'd7,
                 10'h14, 0, 2);
      run_access("lbu_top", 1'b1, 1'b0, 3'b100, 32'h3, 32'h0, 32'hF012_3456, 1'b1, 2'b00, 5'd8,
                 10'h18, 0, 1);
      run_access("lb_top", 1'b1, 1'b0, 3'b000, 32'h3, 32'h0, 32'hF012_3456, 1'b1, 2'b00, 5'd9,
                 10'h1C, 1, 1);
      run_access("sw_gnt_late", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2'b00,
                 5'd0, 10'h20, 3, 0);
      run_access("sh_upper", 1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_C3A5, 32'h0, 1'b0, 2'b00, 5'd0,
                 10'h24, 1, 0);
   endtask

   task automatic test_misaligned();
      run_access("lw_misaligned", 1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 32'h1111_2222, 1'b1, 2'b00,
                 5'd5, 10'h28, 0, 1);
      run_access("sh_misaligned", 1'b0, 1'b1, 3'b001, 32'h101, 32'h55AA, 32'h0, 1'b0, 2'b00,
                 5'd0, 10'h2C, 0, 0);
      run_access("lhu_misaligned", 1'b1, 1'b0, 3'b101, 32'h3, 32'h0, 32'h0, 1'b1, 2'b00, 5'd6,
                 10'h30, 0, 1);
   endtask

   task automatic test_reset_mid();
      alu_result = 32'h8;  resultsrc = 2'b01;  f3 = 3'b010;  regwrite = 1'b1;  rd_addr = 5'd3;
      gnt = 1'b1;
      @(posedge clk);
      #1;
      gnt = 1'b0;
      @(negedge clk);
      vectors++;
      if (stall !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid wait_rvalid stall: got %b expected 1", stall);
      end
      rst_n = 1'b0;
      #1;
      check_quiet("reset_mid asserted");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_idle();
      @(negedge clk);
      check_quiet("reset_mid released");
      @(posedge clk);
      #1;
      rvalid = 1'b1;
      rdata  = $urandom;
      @(negedge clk);
      check_quiet("reset_mid stray rvalid");
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      check_quiet("reset_mid after stray");
   endtask

   task automatic test_random_back_to_back();
      logic [31:0] addr;
      logic [2:0]  code;
      int          kind;
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 2);
         code = 3'($urandom_range(0, 7));
         if (kind == 1) code = 3'($urandom_range(0, 2));
         addr = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         run_access($sformatf("rand%0d", i), kind == 0, kind == 1, code, addr, $urandom, $urandom,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00,
                    5'($urandom_range(0, 31)), 10'($urandom_range(0, 1023)),
                    $urandom_range(0, 3), $urandom_range(1, 3));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_misaligned();
      test_reset_mid();
      test_random_back_to_back();
      drive_idle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
